seg_scan_decoder: RTL
=====================

Name: seg_scan_decoder

Overview:
- Receive-side counterpart of the stopwatch's multiplexed 4-digit seven-segment driver.
- Watches the scanned anode/segment bus, waits for each digit's drive to settle, then decodes the segment pattern back to a digit value.
- Assembles complete 4-digit frames and converts MM:SS to a binary seconds count.
- Used as an on-board loopback monitor and as the display checker in benches.

Parameters:
- SETTLE_CYCLES, 16: consecutive cycles the {an,seg} pair must hold unchanged before it is sampled; must be >= 2.
- TIMEOUT_CYCLES, 400000: cycles without any sample before the decoder declares the display stale.

Ports:
- clk, input, 1: system clock.
- rst, input, 1: synchronous, active-high reset.
- an, input, 4: anode enables, active-low, one digit per bit; bit 0 is the rightmost digit.
- seg, input, 8: segment drives, active-low; seg[7..1] = a..g, seg[0] = dp.
- digit0..digit3, output, 4 each: decoded digits from the last complete frame; 0-9, 4'hA = blank, 4'hF = invalid.
- dp, output, 4: captured decimal-point state per digit (1 = lit).
- frame_valid, output, 1: one-cycle pulse when new digit outputs are published.
- seconds, output, 13: digit3*600 + digit2*60 + digit1*10 + digit0.
- seconds_valid, output, 1: high while all four published digits are 0-9.
- stale, output, 1: TIMEOUT_CYCLES elapsed without a sample.
- err, output, 1: sticky flag; set when a settled sample has more than one anode low.

Behaviour:
- Reset values:
  - digits = 4'hA, dp = 0, seconds = 0.
  - frame_valid, seconds_valid, stale and err = 0.
  - internal seen mask, settle counter and timeout counter = 0.
- Input stage:
  - {an,seg} is registered once.
  - The settle counter clears when the registered value differs from the previous cycle's value; otherwise it increments, saturating at SETTLE_CYCLES.
  - A sample event fires on the single cycle the counter transitions to SETTLE_CYCLES-1, so each stable window samples at most once.
- On a sample event:
  - an = 4'b1111: ignored; does not count as a sample for the timeout.
  - Exactly one anode bit low (index k): decode seg[7:1] into shadow[k], store ~seg[0] into dp_shadow[k], set seen[k].
  - Two or more anode bits low: set err; no capture.
- Decode of seg[7:1], active-low codes (dp ignored):
  - 0 = 7'h01, 1 = 7'h4F, 2 = 7'h12, 3 = 7'h06, 4 = 7'h4C.
  - 5 = 7'h24, 6 = 7'h20, 7 = 7'h0F, 8 = 7'h00, 9 = 7'h04.
  - 7'h7F = blank (4'hA).
  - Any other code = invalid (4'hF).
- Capturing an index already in seen before the frame completes overwrites the shadow value. This is not an error.
- Frame completion:
  - The cycle after seen becomes 4'b1111: copy shadows to digit0..3 and dp, pulse frame_valid, clear seen.
  - seconds and seconds_valid update in that same cycle (registered arithmetic, unsigned, 13-bit; maximum 6039 is never truncated).
  - When seconds_valid = 0, seconds holds its previous value.
- Timeout:
  - The counter clears on every accepted sample and increments otherwise.
  - On reaching TIMEOUT_CYCLES: set stale, clear seen, hold the counter.
  - stale clears on the next frame_valid.
- A sample that completes a frame in the same cycle as the timeout expires: the sample wins; the counter clears and stale is not set.
- rst mid-frame discards all partial shadows. err clears only on rst.
- Latency: frame_valid asserts SETTLE_CYCLES+2 cycles after the final digit's drive first becomes stable.

Decomposition:
- Package seg_scan_pkg holds:
  - the ten digit code constants and BLANK_CODE (7'h7F);
  - DIG_BLANK = 4'hA and DIG_INVALID = 4'hF;
  - SECONDS_W = 13.
- Sub-module seg_pattern_decode: purely combinational, 7-bit pattern -> 4-bit digit. It is shared with the bench's scoreboard.

Test Plan:
- Scan 12:34 (each digit held 2000 cycles, order 0-1-2-3) -> frame_valid once per scan; digits 1,2,3,4; seconds = 754; seconds_valid = 1.
- Digits 0 and 1 driven 7'h7F while digits 2-3 show 05 -> digit0 = digit1 = 4'hA; seconds_valid = 0; seconds keeps its prior value.
- Inject a 10-cycle seg glitch (7'h00) within digit 2's window on a 59:59 scan -> not captured; digit2 = 9; seconds = 3599.
- Hold an = 4'b1100 for 100 cycles -> err = 1 and stays 1 until rst; no capture of index 0 or 1 from that window.
- Stop scanning (an = 4'b1111) for TIMEOUT_CYCLES -> stale = 1; resume a valid 00:07 scan -> stale = 0 on frame_valid; seconds = 7.
- Assert rst after digits 0-2 are captured, then scan 3 only -> no frame_valid; a full rescan 10:00 -> seconds = 600.

Source files
------------

// File: rtl/seg_scan_pkg.sv
// Shared constants for the seven-segment scan decoder: segment codes, digit
// sentinels and the MM:SS to seconds conversion.
package seg_scan_pkg;

   localparam int unsigned SECONDS_W = 13;
   localparam int unsigned DIGIT_W   = 4;
   localparam int unsigned PATTERN_W = 7;

   // Active-low a..g patterns as driven on seg[7:1]
   localparam logic [PATTERN_W-1:0] CODE_0     = 7'h01;
   localparam logic [PATTERN_W-1:0] CODE_1     = 7'h4F;
   localparam logic [PATTERN_W-1:0] CODE_2     = 7'h12;
   localparam logic [PATTERN_W-1:0] CODE_3     = 7'h06;
   localparam logic [PATTERN_W-1:0] CODE_4     = 7'h4C;
   localparam logic [PATTERN_W-1:0] CODE_5     = 7'h24;
   localparam logic [PATTERN_W-1:0] CODE_6     = 7'h20;
   localparam logic [PATTERN_W-1:0] CODE_7     = 7'h0F;
   localparam logic [PATTERN_W-1:0] CODE_8     = 7'h00;
   localparam logic [PATTERN_W-1:0] CODE_9     = 7'h04;
   localparam logic [PATTERN_W-1:0] BLANK_CODE = 7'h7F;

   localparam logic [DIGIT_W-1:0] DIG_BLANK   = 4'hA;
   localparam logic [DIGIT_W-1:0] DIG_INVALID = 4'hF;

   typedef struct packed {
      logic [3:0] an;
      logic [7:0] seg;
   } scan_bus_t;

   function automatic logic [SECONDS_W-1:0] mmss_to_sec(
      input logic [DIGIT_W-1:0] d3,
      input logic [DIGIT_W-1:0] d2,
      input logic [DIGIT_W-1:0] d1,
      input logic [DIGIT_W-1:0] d0
   );
      mmss_to_sec = SECONDS_W'(d3) * SECONDS_W'(600) + SECONDS_W'(d2) * SECONDS_W'(60)
                  + SECONDS_W'(d1) * SECONDS_W'(10)  + SECONDS_W'(d0);
   endfunction

endpackage

// File: rtl/seg_scan_decoder_decode.sv
// Combinational seven-segment pattern to digit decoder (0-9, blank, invalid).
module seg_pattern_decode
   import seg_scan_pkg::*;
(
   input  logic [PATTERN_W-1:0] i_pattern,
   output logic [DIGIT_W-1:0]   o_digit_c
);

   always_comb begin
      o_digit_c = DIG_INVALID;
      case (i_pattern)
         CODE_0:     o_digit_c = 4'd0;
         CODE_1:     o_digit_c = 4'd1;
         CODE_2:     o_digit_c = 4'd2;
         CODE_3:     o_digit_c = 4'd3;
         CODE_4:     o_digit_c = 4'd4;
         CODE_5:     o_digit_c = 4'd5;
         CODE_6:     o_digit_c = 4'd6;
         CODE_7:     o_digit_c = 4'd7;
         CODE_8:     o_digit_c = 4'd8;
         CODE_9:     o_digit_c = 4'd9;
         BLANK_CODE: o_digit_c = DIG_BLANK;
         default:    o_digit_c = DIG_INVALID;
      endcase
   end

endmodule

// File: rtl/seg_scan_decoder.sv
// Monitors a multiplexed 4-digit seven-segment bus, samples each digit once it
// has settled, and publishes whole frames plus the equivalent MM:SS seconds.
module seg_scan_decoder
   import seg_scan_pkg::*;
#(
   parameter int unsigned SETTLE_CYCLES  = 16,
   parameter int unsigned TIMEOUT_CYCLES = 400000
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [3:0]           an,
   input  logic [7:0]           seg,
   output logic [3:0]           digit0,
   output logic [3:0]           digit1,
   output logic [3:0]           digit2,
   output logic [3:0]           digit3,
   output logic [3:0]           dp,
   output logic                 frame_valid,
   output logic [SECONDS_W-1:0] seconds,
   output logic                 seconds_valid,
   output logic                 stale,
   output logic                 err
);

   localparam int unsigned SET_W = $clog2(SETTLE_CYCLES + 1);
   localparam int unsigned TMO_W = $clog2(TIMEOUT_CYCLES + 1);

   scan_bus_t                   r_in;
   scan_bus_t                   r_in_prev;
   logic [SET_W-1:0]            r_settle;
   logic [TMO_W-1:0]            r_tmo;
   logic [3:0]                  r_seen;
   logic [3:0][DIGIT_W-1:0]     r_shadow;
   logic [3:0]                  r_dp_shadow;
   logic [3:0][DIGIT_W-1:0]     r_digit;
   logic [3:0]                  r_dp;
   logic                        r_frame_valid;
   logic [SECONDS_W-1:0]        r_seconds;
   logic                        r_seconds_valid;
   logic                        r_stale;
   logic                        r_err;

   logic                        w_sample;
   logic [3:0]                  w_an_low;
   logic                        w_one_hot;
   logic                        w_multi;
   logic                        w_capture;
   logic [1:0]                  w_idx;
   logic [DIGIT_W-1:0]          w_digit;
   logic                        w_publish;
   logic                        w_expire;
   logic                        w_all_num;
   logic [SECONDS_W-1:0]        w_sec;
   logic [3:0]                  w_seen_nxt;

   seg_pattern_decode u_decode (
      .i_pattern (r_in.seg[7:1]),
      .o_digit_c (w_digit)
   );

   // Input register and settle counter; sample fires once per stable window
   always_ff @(posedge clk) begin
      if (rst) begin
         r_in      <= '1;
         r_in_prev <= '1;
         r_settle  <= '0;
      end else begin
         r_in      <= {an, seg};
         r_in_prev <= r_in;
         if (r_in != r_in_prev) begin
            r_settle <= '0;
         end else if (r_settle != SET_W'(SETTLE_CYCLES)) begin
            r_settle <= r_settle + SET_W'(1);
         end
      end
   end

   always_comb begin
      w_sample  = (r_in == r_in_prev) && (r_settle == SET_W'(SETTLE_CYCLES - 2));
      w_an_low  = ~r_in.an;
      w_one_hot = (w_an_low != 4'd0) && ((w_an_low & (w_an_low - 4'd1)) == 4'd0);
      w_multi   = (w_an_low != 4'd0) && !w_one_hot;
      w_capture = w_sample && w_one_hot;
      w_idx     = 2'd0;
      for (int i = 0; i < 4; i++) begin
         if (w_an_low[i]) w_idx = 2'(i);
      end
      w_publish = (r_seen == 4'hF);
      w_expire  = !w_capture && (r_tmo == TMO_W'(TIMEOUT_CYCLES - 1));
      w_all_num = 1'b1;
      for (int i = 0; i < 4; i++) begin
         if (r_shadow[i] > 4'd9) w_all_num = 1'b0;
      end
      w_sec      = mmss_to_sec(r_shadow[3], r_shadow[2], r_shadow[1], r_shadow[0]);
      w_seen_nxt = (w_publish || w_expire) ? 4'd0 : r_seen;
      if (w_capture) w_seen_nxt[w_idx] = 1'b1;
   end

   // Shadow capture, frame publish, timeout and error tracking
   always_ff @(posedge clk) begin
      if (rst) begin
         r_seen          <= '0;
         r_shadow        <= {4{DIG_BLANK}};
         r_dp_shadow     <= '0;
         r_digit         <= {4{DIG_BLANK}};
         r_dp            <= '0;
         r_frame_valid   <= 1'b0;
         r_seconds       <= '0;
         r_seconds_valid <= 1'b0;
         r_stale         <= 1'b0;
         r_err           <= 1'b0;
         r_tmo           <= '0;
      end else begin
         r_frame_valid <= w_publish;
         r_seen        <= w_seen_nxt;
         if (w_capture) begin
            r_shadow[w_idx]    <= w_digit;
            r_dp_shadow[w_idx] <= ~r_in.seg[0];
         end
         if (w_sample && w_multi) r_err <= 1'b1;
         if (w_capture) begin
            r_tmo <= '0;
         end else if (r_tmo != TMO_W'(TIMEOUT_CYCLES)) begin
            r_tmo <= r_tmo + TMO_W'(1);
         end
         if (w_expire) r_stale <= 1'b1;
         if (w_publish) begin
            r_digit <= r_shadow;
            r_dp    <= r_dp_shadow;
            r_stale <= 1'b0;
            r_seconds_valid <= w_all_num;
            if (w_all_num) r_seconds <= w_sec;
         end
      end
   end

   assign digit0        = r_digit[0];
   assign digit1        = r_digit[1];
   assign digit2        = r_digit[2];
   assign digit3        = r_digit[3];
   assign dp            = r_dp;
   assign frame_valid   = r_frame_valid;
   assign seconds       = r_seconds;
   assign seconds_valid = r_seconds_valid;
   assign stale         = r_stale;
   assign err           = r_err;

endmodule
